// File: rtl/wasm_branch_unwinder.sv
// Branch unwinder for br/br_if/br_table: resolves the target label, slides the
// branch results down the operand stack, pops labels and returns the target PC.

package wasm_branch_unwinder_pkg;

  localparam int unsigned LBL_PC_W  = 32;
  localparam int unsigned LBL_OSP_W = 16;
  localparam int unsigned ARITY_W   = 8;

  // One label-stack entry as presented on the branch_target port.
  typedef struct packed {
    logic [LBL_PC_W-1:0]  target_pc;
    logic [LBL_OSP_W-1:0] stack_height;
    logic [ARITY_W-1:0]   arity;
    logic                 is_loop;
  } label_entry_t;

endpackage

module wasm_branch_unwinder
  import wasm_branch_unwinder_pkg::*;
#(
  parameter int unsigned VALUE_W = 64,
  parameter int unsigned OSP_W   = 16,
  parameter int unsigned PC_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [7:0]         req_depth,
  output logic [7:0]         lbl_depth,
  input  label_entry_t       lbl_target,
  input  logic [7:0]         lbl_sp,
  output logic               lbl_pop_en,
  input  logic [OSP_W-1:0]   osp,
  output logic [OSP_W-1:0]   os_rd_addr,
  input  logic [VALUE_W-1:0] os_rd_data,
  output logic               os_wr_en,
  output logic [OSP_W-1:0]   os_wr_addr,
  output logic [VALUE_W-1:0] os_wr_data,
  output logic               os_set_sp_en,
  output logic [OSP_W-1:0]   os_set_sp_value,
  output logic               done,
  output logic               trap,
  output logic [PC_W-1:0]    target_pc
);

  localparam int unsigned HK_W = OSP_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_COPY_RD,
    S_COPY_WR,
    S_COMMIT
  } state_t;

  state_t             state;
  logic [OSP_W-1:0]   h_q;
  logic [ARITY_W-1:0] k_q;
  logic [OSP_W-1:0]   osp_q;
  logic [ARITY_W-1:0] idx_q;

  logic [ARITY_W-1:0] k_c;
  logic [HK_W-1:0]    hk_c;
  logic               trap_c;
  logic [ARITY_W:0]   idx_next_c;

  // Branch arity, unwound height and fault detection from the live label entry.
  always_comb begin
    k_c        = lbl_target.is_loop ? '0 : lbl_target.arity;
    hk_c       = HK_W'(lbl_target.stack_height) + HK_W'(k_c);
    trap_c     = (lbl_depth >= lbl_sp) || (HK_W'(osp) < hk_c);
    idx_next_c = (ARITY_W+1)'(idx_q) + (ARITY_W+1)'(1);
  end

  // Read data arrives in COPY_WR, the same cycle the write strobe is up.
  assign os_wr_data = os_rd_data;

  // Unwind sequencer with registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      req_ready       <= 1'b1;
      lbl_depth       <= '0;
      lbl_pop_en      <= 1'b0;
      os_rd_addr      <= '0;
      os_wr_en        <= 1'b0;
      os_wr_addr      <= '0;
      os_set_sp_en    <= 1'b0;
      os_set_sp_value <= '0;
      done            <= 1'b0;
      trap            <= 1'b0;
      target_pc       <= '0;
      h_q             <= '0;
      k_q             <= '0;
      osp_q           <= '0;
      idx_q           <= '0;
    end else begin
      lbl_pop_en   <= 1'b0;
      os_wr_en     <= 1'b0;
      os_set_sp_en <= 1'b0;
      done         <= 1'b0;
      trap         <= 1'b0;

      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lbl_depth <= req_depth;
            req_ready <= 1'b0;
            state     <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          h_q   <= OSP_W'(lbl_target.stack_height);
          k_q   <= k_c;
          osp_q <= osp;
          idx_q <= '0;
          if (trap_c) begin
            done      <= 1'b1;
            trap      <= 1'b1;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end else if ((HK_W'(osp) == hk_c) || (k_c == '0)) begin
            target_pc       <= PC_W'(lbl_target.target_pc);
            lbl_pop_en      <= 1'b1;
            os_set_sp_en    <= 1'b1;
            os_set_sp_value <= OSP_W'(hk_c);
            done            <= 1'b1;
            state           <= S_COMMIT;
          end else begin
            target_pc  <= PC_W'(lbl_target.target_pc);
            os_rd_addr <= osp - OSP_W'(k_c);
            state      <= S_COPY_RD;
          end
        end

        S_COPY_RD: begin
          os_wr_en   <= 1'b1;
          os_wr_addr <= h_q + OSP_W'(idx_q);
          state      <= S_COPY_WR;
        end

        S_COPY_WR: begin
          if (idx_next_c < (ARITY_W+1)'(k_q)) begin
            idx_q      <= ARITY_W'(idx_next_c);
            os_rd_addr <= osp_q - OSP_W'(k_q) + OSP_W'(idx_next_c);
            state      <= S_COPY_RD;
          end else begin
            lbl_pop_en      <= 1'b1;
            os_set_sp_en    <= 1'b1;
            os_set_sp_value <= h_q + OSP_W'(k_q);
            done            <= 1'b1;
            state           <= S_COMMIT;
          end
        end

        S_COMMIT: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/wasm_branch_unwinder.md
Name: wasm_branch_unwinder

Overview:
- Executes `br`/`br_if`/`br_table` after the decoder has resolved the branch depth.
- Reads the target label from the label stack and moves the branch's result values down the operand stack.
- Discards the intermediate operands, pops the labels and returns the target PC to the fetch unit.
- Sits between the control unit, the label stack and the operand stack. It is the consumer side of the label stack's branch interface.

Parameters:
- VALUE_W, 64, operand-stack value width
- OSP_W, 16, operand-stack pointer/address width
- PC_W, 32, program-counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  branch request
- req_ready  out  1  unwinder idle, can accept a request
- req_depth  in  8  relative label depth
- lbl_depth  out  8  drives the label stack's branch_depth
- lbl_target  in  label_entry_t  label stack's branch_target (combinational from lbl_depth)
- lbl_sp  in  8  label stack pointer
- lbl_pop_en  out  1  drives the label stack's branch_pop_en
- osp  in  OSP_W  current operand-stack pointer (count of entries)
- os_rd_addr  out  OSP_W  operand-stack read address; data returns one cycle later
- os_rd_data  in  VALUE_W  operand-stack read data
- os_wr_en  out  1  operand-stack write strobe
- os_wr_addr  out  OSP_W  write address
- os_wr_data  out  VALUE_W  write data
- os_set_sp_en  out  1  load operand-stack pointer
- os_set_sp_value  out  OSP_W  new operand-stack pointer
- done  out  1  one-cycle completion pulse
- trap  out  1  valid with done: branch faulted
- target_pc  out  PC_W  valid with done when trap=0

Behaviour:
- label_entry_t fields used: target_pc, stack_height, arity, is_loop.
  - Branch arity k = 0 if is_loop, else arity (MVP: loops take no params).
- Reset (rst=1 at a clock edge): state IDLE, req_ready=1, all strobes (lbl_pop_en, os_wr_en, os_set_sp_en, done, trap)=0, target_pc=0, lbl_depth=0.
  - Reset mid-operation aborts immediately with no further strobes. Writes already issued are not undone.
- FSM: IDLE -> LOOKUP -> {COPY_RD <-> COPY_WR}* -> COMMIT -> IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch depth, hold lbl_depth=depth, go to LOOKUP. req_ready=0 in all other states.
- LOOKUP (1 cycle):
  - Latch target_pc, stack_height h, k from lbl_target, and latch osp.
  - Trap if depth >= lbl_sp or osp < h+k: assert done=1, trap=1, no strobes, return to IDLE.
  - If osp == h+k (nothing to discard) or k == 0: go to COMMIT.
  - Otherwise set i=0 and go to COPY_RD.
- COPY_RD: os_rd_addr = osp-k+i.
- COPY_WR: os_wr_en=1, os_wr_addr=h+i, os_wr_data=os_rd_data.
  - i++; go to COPY_RD if i<k, else COMMIT.
- Copy order is ascending. This is safe because destination <= source. Each value takes 2 cycles.
- COMMIT (1 cycle):
  - lbl_pop_en=1 with lbl_depth still driven.
  - os_set_sp_en=1, os_set_sp_value=h+k.
  - done=1, trap=0, target_pc valid.
  - Then IDLE.
- Latency from accept edge to done:
  - 2 cycles with no copy.
  - 2+2k cycles with copy.
  - 2 cycles on trap.
- Address arithmetic is OSP_W-bit unsigned. h+k is computed at OSP_W+1 bits, so the trap comparison does not wrap.
- target_pc holds its last value between requests. done and trap are single-cycle pulses.
- req_valid while busy is ignored; the requester must hold it until it sees req_ready.
- Operand-stack and label-stack state must not be changed by other agents while the unwinder is busy. The control unit guarantees this.

Test Plan:
- Block branch, depth=0, label {pc=0x40, h=2, arity=1, block}, osp=5, stack[4]=0xAA: exactly one write stack[2]=0xAA; COMMIT sets osp=3, lbl_pop_en=1, target_pc=0x40; done 4 cycles after accept.
- Loop branch, depth=1, label {pc=0x10, h=0, arity=2, loop}, osp=3: no writes; osp set to 0; done at 2 cycles.
- Multi-value branch, arity=3, h=1, osp=7, stack[4..6]=A,B,C: writes stack[1]=A, stack[2]=B, stack[3]=C in order; osp set to 4; done at 8 cycles.
- Trap cases:
  - depth=3 with lbl_sp=3 -> done=1, trap=1 at 2 cycles; no lbl_pop_en, os_wr_en or os_set_sp_en.
  - osp=2, h=2, arity=1 -> same trap response.
- No-discard branch, osp==h+arity: zero writes, direct to COMMIT; back-to-back requests accepted on the cycle after done.
- Assert rst during COPY_WR of a 3-value branch: next cycle all strobes 0, req_ready=1; no COMMIT; a following request completes normally.
